dot_matrix_scheduler: RTL and testbench

Owns the 16x16 LED dot-matrix panel and shares it between several picture sources: washer-state animation, warning overlay and countdown/message.
- Generates row-scan timing (row select, row/frame ticks).
- Arbitrates panel ownership at frame boundaries by fixed priority with a minimum hold time.
- Inserts one blank frame on every ownership change so no ghosting occurs.
- Sources become pure row-to-column lookup blocks driven by this scheduler.

---
 rtl/dot_matrix_scheduler_pkg.sv | 31 +++
 rtl/dot_matrix_scheduler_if.sv | 39 +++
 rtl/dot_matrix_scan_timer.sv | 61 ++++++
 rtl/dot_matrix_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_dot_matrix_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_matrix_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dot_matrix_scheduler_pkg
// Purpose  : Panel geometry, blank column pattern, row-select helper and the
//            scheduler state encoding for the 16x16 dot-matrix scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dot_matrix_scheduler_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  // Columns are active-low, so all-ones is a dark row.
  localparam logic [COLS-1:0] BLANK_COL = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } sched_state_e;

  // Active-low one-hot row select; bit 15 drives row 0.
  function automatic logic [ROWS-1:0] row_onehot_n(input logic [3:0] idx);
    logic [ROWS-1:0] sel;
    sel = '1;
    sel[4'd15 - idx] = 1'b0;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dot_matrix_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : dot_matrix_scheduler_if
// Purpose   : Source-side (request / column lookup / grant) and panel-side
//             (row/column drive, scan ticks) signals of the scheduler.
// Revision  : 1.0 - initial release
// ============================================================================
interface dot_matrix_scheduler_if #(
  parameter int N_SRC = 3
);
  import dot_matrix_scheduler_pkg::*;

  logic [N_SRC-1:0]      req;
  logic [COLS*N_SRC-1:0] col_in;
  logic [N_SRC-1:0]      grant;
  logic [3:0]            fetch_row;
  logic [3:0]            row_idx;
  logic [ROWS-1:0]       row_sel;
  logic [COLS-1:0]       col_out;
  logic                  row_tick;
  logic                  frame_tick;
  logic                  blanking;

  // Scheduler side.
  modport master (
    input  req, col_in,
    output grant, fetch_row, row_idx, row_sel, col_out,
           row_tick, frame_tick, blanking
  );

  // Picture sources and panel driver side.
  modport slave (
    output req, col_in,
    input  grant, fetch_row, row_idx, row_sel, col_out,
           row_tick, frame_tick, blanking
  );

endinterface
`default_nettype wire

// File: rtl/dot_matrix_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : dot_matrix_scan_timer
// Purpose  : Row-scan timing: prescaler, current row, active-low row select,
//            row and frame tick pulses.
// Revision : 1.0 - initial release
// ============================================================================
module dot_matrix_scan_timer
  import dot_matrix_scheduler_pkg::*;
#(
  parameter int CLK_DIV = 9375
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  output logic [3:0]      row_idx,
  output logic [3:0]      fetch_row,
  output logic [ROWS-1:0] row_sel,
  output logic            row_tick,
  output logic            frame_tick
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_row_idx;
  logic [ROWS-1:0]  r_row_sel;
  logic             w_row_tick;
  logic [3:0]       w_fetch_row;

  assign w_row_tick  = (r_cnt == CNT_LAST);
  assign w_fetch_row = r_row_idx + 4'd1;

  // Prescaler and row advance; row and its select move together on a row tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_row_idx <= 4'd0;
      r_row_sel <= row_onehot_n(4'd0);
    end else if (!clr) begin
      r_cnt     <= '0;
      r_row_idx <= 4'd0;
      r_row_sel <= row_onehot_n(4'd0);
    end else if (w_row_tick) begin
      r_cnt     <= '0;
      r_row_idx <= w_fetch_row;
      r_row_sel <= row_onehot_n(w_fetch_row);
    end else begin
      r_cnt     <= r_cnt + 1'b1;
    end
  end

  assign row_idx    = r_row_idx;
  assign fetch_row  = w_fetch_row;
  assign row_sel    = r_row_sel;
  assign row_tick   = w_row_tick;
  assign frame_tick = w_row_tick && (r_row_idx == 4'd15);

endmodule
`default_nettype wire

// File: rtl/dot_matrix_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dot_matrix_scheduler
// Purpose  : Shares the 16x16 LED panel between picture sources. Ownership is
//            decided at frame boundaries by fixed priority with a minimum
//            hold time, and every ownership change passes through one blank
//            frame.
// Revision : 1.0 - initial release
// ============================================================================
module dot_matrix_scheduler
  import dot_matrix_scheduler_pkg::*;
#(
  parameter int CLK_DIV         = 9375,
  parameter int N_SRC           = 3,
  parameter int MIN_HOLD_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  dot_matrix_scheduler_if.master bus
);

  localparam int                IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int                SLOTS    = 1 << IDX_W;
  localparam int                HOLD_W   = $clog2(MIN_HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_FRAMES);

  logic             w_row_tick;
  logic             w_frame_tick;
  logic [3:0]       w_fetch_row;
  logic [3:0]       w_row_idx;
  logic [ROWS-1:0]  w_row_sel;

  // Source requests and columns padded to a power-of-two slot count so every
  // index value selects a defined entry.
  logic [SLOTS-1:0] w_req;
  logic [COLS-1:0]  w_src_col [SLOTS];
  logic [IDX_W-1:0] w_top_idx;
  logic             w_any_req;

  sched_state_e     r_state;
  sched_state_e     w_next_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_next_owner;
  logic [IDX_W-1:0] r_pending;
  logic [IDX_W-1:0] w_next_pending;
  logic             r_pend_valid;
  logic             w_next_pend_valid;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [N_SRC-1:0] r_grant;
  logic             r_blanking;
  logic [COLS-1:0]  r_col_out;

  dot_matrix_scan_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_scan_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .row_idx    (w_row_idx),
    .fetch_row  (w_fetch_row),
    .row_sel    (w_row_sel),
    .row_tick   (w_row_tick),
    .frame_tick (w_frame_tick)
  );

  for (genvar g = 0; g < SLOTS; g++) begin : g_src_slot
    if (g < N_SRC) begin : g_live
      assign w_req[g]     = bus.req[g];
      assign w_src_col[g] = bus.col_in[COLS*g +: COLS];
    end else begin : g_pad
      assign w_req[g]     = 1'b0;
      assign w_src_col[g] = BLANK_COL;
    end
  end

  assign w_any_req = |w_req;

  // Priority encoder: lowest set request index wins.
  always_comb begin
    w_top_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (w_req[i]) w_top_idx = IDX_W'(i);
    end
  end

  // Arbitration decision; only takes effect on a frame tick.
  always_comb begin
    w_next_state      = r_state;
    w_next_owner      = r_owner;
    w_next_pending    = r_pending;
    w_next_pend_valid = r_pend_valid;
    if (w_frame_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            w_next_state      = ST_BLANK;
            w_next_pending    = w_top_idx;
            w_next_pend_valid = 1'b1;
          end
        end
        ST_BLANK: begin
          if (r_pend_valid && w_req[r_pending]) begin
            w_next_state = ST_SHOW;
            w_next_owner = r_pending;
          end else if (w_any_req) begin
            w_next_state = ST_SHOW;
            w_next_owner = w_top_idx;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_SHOW: begin
          // A dropped request takes precedence over any preemption.
          if (!w_req[r_owner]) begin
            w_next_state      = ST_BLANK;
            w_next_pending    = w_top_idx;
            w_next_pend_valid = w_any_req;
          end else if ((w_top_idx < r_owner) &&
                       ((w_top_idx == '0) || (r_hold_cnt >= HOLD_MAX))) begin
            // Source 0 (warning) ignores the hold time.
            w_next_state      = ST_BLANK;
            w_next_pending    = w_top_idx;
            w_next_pend_valid = 1'b1;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Scheduler FSM with registered grant, blanking flag, hold counter and
  // column latch. The column latched on a row tick belongs to whoever owns
  // the panel for the row being entered, so a frame never mixes owners.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_hold_cnt   <= '0;
      r_grant      <= '0;
      r_blanking   <= 1'b0;
      r_col_out    <= BLANK_COL;
    end else if (!clr) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_hold_cnt   <= '0;
      r_grant      <= '0;
      r_blanking   <= 1'b0;
      r_col_out    <= BLANK_COL;
    end else begin
      if (w_frame_tick) begin
        r_state      <= w_next_state;
        r_owner      <= w_next_owner;
        r_pending    <= w_next_pending;
        r_pend_valid <= w_next_pend_valid;
        r_grant      <= (w_next_state == ST_SHOW) ? (N_SRC'(1) << w_next_owner) : '0;
        r_blanking   <= (w_next_state == ST_BLANK);
        if ((w_next_state == ST_SHOW) && (r_state != ST_SHOW)) begin
          r_hold_cnt <= '0;
        end else if ((r_state == ST_SHOW) && (r_hold_cnt != HOLD_MAX)) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
      if (w_row_tick) begin
        r_col_out <= (w_next_state == ST_SHOW) ? w_src_col[w_next_owner] : BLANK_COL;
      end
    end
  end

  assign bus.grant      = r_grant;
  assign bus.blanking   = r_blanking;
  assign bus.col_out    = r_col_out;
  assign bus.fetch_row  = w_fetch_row;
  assign bus.row_idx    = w_row_idx;
  assign bus.row_sel    = w_row_sel;
  assign bus.row_tick   = w_row_tick;
  assign bus.frame_tick = w_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_matrix_scheduler
// Purpose  : Self-checking bench for dot_matrix_scheduler with directed
//            scenarios and randomized request traffic against a frame-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_matrix_scheduler;

  localparam int CLK_DIV  = 4;
  localparam int N_SRC    = 3;
  localparam int MIN_HOLD = 2;
  localparam int FRAME    = 16 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b1;
  logic [N_SRC-1:0]    req_drv = '0;
  logic [16*N_SRC-1:0] w_col_in;
  logic [15:0]         img [N_SRC][16];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: cycle count since reset plus frame-level panel owner.
  int m_cyc;
  int m_mode;     // 0 idle, 1 blank, 2 show
  int m_own;
  int m_pend;
  bit m_pv;
  int m_shown;    // frame ticks seen by the current owner

  dot_matrix_scheduler_if #(.N_SRC(N_SRC)) bus ();

  dot_matrix_scheduler #(
    .CLK_DIV         (CLK_DIV),
    .N_SRC           (N_SRC),
    .MIN_HOLD_FRAMES (MIN_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Sources behave as row lookup tables addressed by fetch_row.
  always_comb begin
    w_col_in = '0;
    for (int s = 0; s < N_SRC; s++) w_col_in[16*s +: 16] = img[s][bus.fetch_row];
  end
  assign bus.col_in = w_col_in;
  assign bus.req    = req_drv;

  function automatic int lowest(input logic [N_SRC-1:0] r);
    for (int i = 0; i < N_SRC; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic int e_row();
    return (m_cyc / CLK_DIV) % 16;
  endfunction

  function automatic logic e_rt();
    return (m_cyc % CLK_DIV) == CLK_DIV - 1;
  endfunction

  function automatic logic e_ft();
    return (m_cyc % FRAME) == FRAME - 1;
  endfunction

  function automatic logic [15:0] e_rowsel();
    logic [15:0] v;
    v = '1;
    v[15 - e_row()] = 1'b0;
    return v;
  endfunction

  function automatic logic [15:0] e_col();
    return (m_mode == 2) ? img[m_own][e_row()] : 16'hFFFF;
  endfunction

  function automatic logic [N_SRC-1:0] e_grant();
    return (m_mode == 2) ? N_SRC'(1 << m_own) : '0;
  endfunction

  function automatic void model_clear();
    m_cyc = 0; m_mode = 0; m_own = 0; m_pend = 0; m_pv = 1'b0; m_shown = 0;
  endfunction

  // Ownership rules applied once per frame boundary.
  function automatic void arbitrate(input logic [N_SRC-1:0] r);
    int lo;
    lo = lowest(r);
    case (m_mode)
      0: if (lo >= 0) begin m_mode = 1; m_pend = lo; m_pv = 1'b1; end
      1: begin
        if (m_pv && r[m_pend]) begin m_mode = 2; m_own = m_pend; m_shown = 0; end
        else if (lo >= 0)      begin m_mode = 2; m_own = lo;     m_shown = 0; end
        else m_mode = 0;
      end
      default: begin
        if (!r[m_own]) begin
          m_mode = 1; m_pv = (lo >= 0); m_pend = (lo < 0) ? 0 : lo;
        end else if (lo < m_own && (lo == 0 || m_shown >= MIN_HOLD)) begin
          m_mode = 1; m_pv = 1'b1; m_pend = lo;
        end
        m_shown++;
      end
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b0; clr = 1'b1; req_drv = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
  endtask

  // One clock: inputs seen before the edge drive the model, then settle.
  task automatic clk_step();
    logic ft;
    logic c;
    logic [N_SRC-1:0] r;
    ft = e_ft(); c = clr; r = req_drv;
    @(posedge clk);
    if (!c) model_clear();
    else begin
      m_cyc++;
      if (ft) arbitrate(r);
    end
    #1;
  endtask

  task automatic rand_img();
    for (int s = 0; s < N_SRC; s++)
      for (int r = 0; r < 16; r++) img[s][r] = 16'($urandom);
  endtask

  task automatic test_reset();
    int n_rt, n_ft;
    rand_img();
    do_reset();
    n_cmp++; if (bus.row_sel !== 16'h7FFF) begin n_fail++; $display("FAIL reset_row_sel got %h want 7fff", bus.row_sel); end
    n_cmp++; if (bus.col_out !== 16'hFFFF) begin n_fail++; $display("FAIL reset_col_out got %h want ffff", bus.col_out); end
    n_cmp++; if (bus.grant !== 3'b000 || bus.blanking !== 1'b0) begin n_fail++; $display("FAIL reset_grant got %b/%b want 000/0", bus.grant, bus.blanking); end
    n_cmp++; if (bus.row_idx !== 4'd0 || bus.fetch_row !== 4'd1 || bus.row_tick !== 1'b0 || bus.frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_scan got row=%0d fetch=%0d rt=%b ft=%b want 0/1/0/0", bus.row_idx, bus.fetch_row, bus.row_tick, bus.frame_tick);
    end
    n_rt = 0; n_ft = 0;
    for (int c = 0; c < 2*FRAME; c++) begin
      n_rt += int'(bus.row_tick);
      n_ft += int'(bus.frame_tick);
      n_cmp++;
      if (bus.row_sel !== e_rowsel() || bus.row_idx !== 4'(e_row()) || bus.row_tick !== e_rt() ||
          bus.frame_tick !== e_ft() || bus.col_out !== 16'hFFFF || bus.grant !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_scan cyc=%0d got sel=%h row=%0d rt=%b ft=%b col=%h gr=%b want sel=%h row=%0d rt=%b ft=%b col=ffff gr=000",
                 m_cyc, bus.row_sel, bus.row_idx, bus.row_tick, bus.frame_tick, bus.col_out, bus.grant,
                 e_rowsel(), e_row(), e_rt(), e_ft());
      end
      clk_step();
    end
    n_cmp++; if (n_rt != 32 || n_ft != 2) begin n_fail++; $display("FAIL tick_count got rt=%0d ft=%0d want 32/2", n_rt, n_ft); end
  endtask

  task automatic test_first_grant();
    rand_img();
    for (int r = 0; r < 16; r++) img[2][r] = 16'h0F0F;
    do_reset();
    req_drv = 3'b100;
    repeat (FRAME) clk_step();
    for (int c = 0; c < FRAME; c++) begin
      n_cmp++;
      if (bus.col_out !== 16'hFFFF || bus.blanking !== 1'b1 || bus.grant !== 3'b000) begin
        n_fail++; $display("FAIL blank_frame cyc=%0d got col=%h bl=%b gr=%b want ffff/1/000", m_cyc, bus.col_out, bus.blanking, bus.grant);
      end
      clk_step();
    end
    n_cmp++;
    if (bus.grant !== 3'b100 || bus.col_out !== 16'h0F0F || bus.row_sel !== 16'h7FFF || bus.blanking !== 1'b0) begin
      n_fail++; $display("FAIL first_show got gr=%b col=%h sel=%h bl=%b want 100/0f0f/7fff/0", bus.grant, bus.col_out, bus.row_sel, bus.blanking);
    end
    for (int c = 0; c < FRAME; c++) begin
      clk_step();
      n_cmp++;
      if (bus.col_out !== 16'h0F0F || bus.grant !== 3'b100 || bus.row_sel !== e_rowsel()) begin
        n_fail++; $display("FAIL show_rows cyc=%0d got col=%h gr=%b sel=%h want 0f0f/100/%h", m_cyc, bus.col_out, bus.grant, bus.row_sel, e_rowsel());
      end
    end
  endtask

  task automatic test_hold();
    rand_img();
    do_reset();
    req_drv = 3'b100;
    repeat (2*FRAME) clk_step();
    n_cmp++; if (bus.grant !== 3'b100) begin n_fail++; $display("FAIL hold_entry got %b want 100", bus.grant); end
    repeat (FRAME + FRAME/2) clk_step();
    req_drv = 3'b110;
    repeat (FRAME/2) clk_step();
    n_cmp++; if (bus.grant !== 3'b100 || bus.blanking !== 1'b0) begin n_fail++; $display("FAIL hold_keep got %b/%b want 100/0", bus.grant, bus.blanking); end
    repeat (FRAME) clk_step();
    n_cmp++; if (bus.grant !== 3'b000 || bus.blanking !== 1'b1) begin n_fail++; $display("FAIL hold_blank got %b/%b want 000/1", bus.grant, bus.blanking); end
    repeat (FRAME) clk_step();
    n_cmp++; if (bus.grant !== 3'b010 || bus.blanking !== 1'b0 || bus.col_out !== img[1][0]) begin
      n_fail++; $display("FAIL hold_switch got %b/%b/%h want 010/0/%h", bus.grant, bus.blanking, bus.col_out, img[1][0]);
    end
  endtask

  task automatic test_preempt();
    rand_img();
    do_reset();
    req_drv = 3'b100;
    repeat (2*FRAME + 20) clk_step();
    req_drv = 3'b101;
    repeat (FRAME - 21) clk_step();
    n_cmp++; if (bus.grant !== 3'b100 || bus.row_idx !== 4'd15 || bus.col_out !== img[2][15]) begin
      n_fail++; $display("FAIL preempt_last_row got %b/%0d/%h want 100/15/%h", bus.grant, bus.row_idx, bus.col_out, img[2][15]);
    end
    clk_step();
    n_cmp++; if (bus.grant !== 3'b000 || bus.blanking !== 1'b1 || bus.col_out !== 16'hFFFF) begin
      n_fail++; $display("FAIL preempt_blank got %b/%b/%h want 000/1/ffff", bus.grant, bus.blanking, bus.col_out);
    end
    repeat (FRAME) clk_step();
    n_cmp++; if (bus.grant !== 3'b001 || bus.col_out !== img[0][0]) begin
      n_fail++; $display("FAIL preempt_grant got %b/%h want 001/%h", bus.grant, bus.col_out, img[0][0]);
    end
  endtask

  task automatic test_blank_drop();
    rand_img();
    do_reset();
    req_drv = 3'b100;
    repeat (FRAME + 20) clk_step();
    req_drv = 3'b010;
    repeat (FRAME - 20) clk_step();
    n_cmp++; if (bus.grant !== 3'b010 || bus.blanking !== 1'b0 || bus.col_out !== img[1][0]) begin
      n_fail++; $display("FAIL drop_regrant got %b/%b/%h want 010/0/%h", bus.grant, bus.blanking, bus.col_out, img[1][0]);
    end
    req_drv = 3'b000;
    repeat (FRAME) clk_step();
    n_cmp++; if (bus.grant !== 3'b000 || bus.blanking !== 1'b1) begin n_fail++; $display("FAIL drop_blank got %b/%b want 000/1", bus.grant, bus.blanking); end
    repeat (FRAME) clk_step();
    n_cmp++; if (bus.grant !== 3'b000 || bus.blanking !== 1'b0 || bus.col_out !== 16'hFFFF) begin
      n_fail++; $display("FAIL drop_idle got %b/%b/%h want 000/0/ffff", bus.grant, bus.blanking, bus.col_out);
    end
  endtask

  task automatic test_clear();
    int guard;
    rand_img();
    do_reset();
    req_drv = 3'b100;
    guard = 0;
    while (!(m_mode == 2 && e_row() == 9) && guard < 400) begin clk_step(); guard++; end
    n_cmp++; if (guard >= 400) begin n_fail++; $display("FAIL clr_setup got no show at row 9 want reached"); end
    clr = 1'b0;
    clk_step();
    clr = 1'b1;
    n_cmp++; if (bus.row_sel !== 16'h7FFF || bus.col_out !== 16'hFFFF || bus.grant !== 3'b000 || bus.blanking !== 1'b0 || bus.row_idx !== 4'd0) begin
      n_fail++; $display("FAIL clr_state got sel=%h col=%h gr=%b bl=%b row=%0d want 7fff/ffff/000/0/0", bus.row_sel, bus.col_out, bus.grant, bus.blanking, bus.row_idx);
    end
    guard = 0;
    while (!(m_mode == 2 && e_row() == 9) && guard < 400) begin clk_step(); guard++; end
    n_cmp++; if (guard >= 400 || bus.grant !== 3'b100) begin n_fail++; $display("FAIL clr_resume got gr=%b want 100", bus.grant); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.row_sel !== 16'h7FFF || bus.col_out !== 16'hFFFF || bus.grant !== 3'b000 || bus.blanking !== 1'b0 || bus.row_idx !== 4'd0) begin
      n_fail++; $display("FAIL async_rst got sel=%h col=%h gr=%b bl=%b row=%0d want 7fff/ffff/000/0/0", bus.row_sel, bus.col_out, bus.grant, bus.blanking, bus.row_idx);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_random();
    rand_img();
    do_reset();
    for (int c = 0; c < 40*FRAME; c++) begin
      if ($urandom_range(0, 47) == 0) req_drv = 3'($urandom_range(0, 7));
      clk_step();
      n_cmp++;
      if (bus.row_idx !== 4'(e_row()) || bus.fetch_row !== 4'(e_row() + 1) || bus.row_sel !== e_rowsel() ||
          bus.row_tick !== e_rt() || bus.frame_tick !== e_ft() || bus.grant !== e_grant() ||
          bus.col_out !== e_col() || bus.blanking !== (m_mode == 1)) begin
        n_fail++;
        $display("FAIL random cyc=%0d req=%b got row=%0d sel=%h gr=%b col=%h bl=%b want row=%0d sel=%h gr=%b col=%h bl=%b",
                 m_cyc, req_drv, bus.row_idx, bus.row_sel, bus.grant, bus.col_out, bus.blanking,
                 e_row(), e_rowsel(), e_grant(), e_col(), (m_mode == 1));
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_grant();
    test_hold();
    test_preempt();
    test_blank_drop();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
